lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port. Accepts one decoded `L_OP`/`S_OP` at a time, sizes it (`BYTE`/`HWORD`/`WORD`, `SIGNED`/`UNSIGNED`), and drives a word-addressed request/grant/response memory interface with byte enables. Aligns and extends load data, writes back to the register file and stalls the pipeline while busy.

## Interface
- `XLEN`, 32, data/address width; only 32 supported.
- `clk` in 1: the single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: memory op offered by execute.
- `req_ready_o` out 1: op accepted when `req_valid_i && req_ready_o`.
- `req_is_store_i` in 1: 1 store, 0 load.
- `req_size_i` in 2 (`size_t`): access size.
- `req_sign_i` in 1 (`sign_t`): load extension.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, LSB-aligned.
- `req_rd_i` in 5 (`reg_t`): load destination.
- `mem_req_o`, `mem_we_o` out 1; `mem_addr_o` out 32, with `[1:0]`=0; `mem_be_o` out 4; `mem_wdata_o` out 32.
- `mem_gnt_i`, `mem_rvalid_i` in 1; `mem_rdata_i` in 32.
- `wb_valid_o` out 1; `wb_rd_o` out 5; `wb_data_o` out 32.
- `exc_misaligned_o` out 1; `exc_addr_o` out 32.
- `busy_o` out 1: pipeline stall, = `!req_ready_o`.

## Operation
- States: `IDLE`, `REQ0`, `WAIT0`, `REQ1`, `WAIT1`, `DONE`, `EXC`.
- `IDLE`: `req_ready_o`=1. On accept, latch all request fields. Next state is `EXC` if the access is unsupported, otherwise `REQ0`.
- `REQn`: `mem_req_o`=1 with stable addr/we/be/wdata until `mem_gnt_i`, then go to `WAITn`.
- `WAITn`: on `mem_rvalid_i`, capture `mem_rdata_i` (loads). The beat is the last one when the access is not split or n=1. Last beat goes to `DONE`; otherwise go to `REQ1`. Stores also complete on `mem_rvalid_i`.
- `DONE`: one cycle. For loads, `wb_valid_o`=1 with assembled data. Return to `IDLE`.
- `EXC`: one cycle. `exc_misaligned_o`=1, `exc_addr_o` = latched address. No memory request, no writeback. Return to `IDLE`.
- Offset o = `addr[1:0]`. Base mask: BYTE 4'b0001, HWORD 4'b0011, WORD 4'b1111.
- 8-bit mask m8 = mask << o.
- Beat 0: `mem_be_o`=m8[3:0], `mem_addr_o`={addr[31:2],2'b00}.
- Beat 1: `mem_be_o`=m8[7:4], `mem_addr_o` = beat-0 address + 4, wraps modulo 2^32.
- Store data: 64-bit value {32'b0,wdata} << 8·o. Beat 0 drives bits [31:0], beat 1 drives bits [63:32].
- Load data: ({rdata1,rdata0} >> 8·o), truncated to size. Zero-extend if `UNSIGNED`, sign-extend if `SIGNED`. rdata1=0 when not split.
- Size 2'b11 is treated as `WORD`.
- `mem_rvalid_i` outside `WAITn` is ignored. `mem_gnt_i` outside `REQn` is ignored.
- One outstanding request. `req_*` inputs are don't-care when not accepted.

## Timing
- Reset values: state `IDLE`, `req_ready_o`=1, `busy_o`=0. All other outputs and latched fields are 0.
- Reset is asynchronous at any state. A response arriving after reset is dropped.
- Accept at cycle 0 gives `mem_req_o` at cycle 1.
- Zero-wait memory (gnt at 1, rvalid at 2): `wb_valid_o` at cycle 3, `req_ready_o` at cycle 4.
- Minimum unsplit op: 4 cycles accept-to-accept.
- Split op: minimum 6 cycles.
- Exception op: 2 cycles; `exc_misaligned_o` at cycle 1.
- `wb_*` and `exc_*` outputs are registered, one-cycle pulses.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - Non-natural accesses inside one word use one beat with shifted `mem_be_o`.
  - Word-crossing accesses split into two beats.
  - `EXC` is unreachable.
- Undefined:
  - Any access with `addr` not a multiple of its size goes to `EXC`.
  - `REQ1`/`WAIT1` are not generated.

## Structure
- Added to package `riscv`:
  - `lsu_state_t` enum.
  - Function `lsu_be_mask(size_t)` returning the 4-bit base mask.
  - Function `lsu_misaligned(size_t, logic[1:0])`.
- Sub-module `lsu_align`, combinational:
  - Store shift to 64 bits.
  - Load 64-bit extract and sign/zero extension.
- FSM and latches stay in `lsu_ctrl`.

## Test plan
- LW x5 from 0x100, gnt immediate, rdata 0xDEADBEEF:
  - `mem_be_o`=4'hF.
  - `wb_valid_o` at cycle 3 with `wb_rd_o`=5 and data 0xDEADBEEF.
- LB signed and LBU from 0x103, rdata 0x80xxxxxx:
  - `mem_be_o`=4'h8.
  - Data 0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH 0x1234 to 0x102, gnt delayed 3 cycles:
  - `mem_req_o` held 4 cycles.
  - `mem_be_o`=4'hC, `mem_wdata_o`=0x12340000.
  - No `wb_valid_o`.
- LW from 0x1FE with macro on, beat 0 rdata 0xAABBxxxx, beat 1 0xxxxxCCDD:
  - Addresses 0x1FC then 0x200.
  - be 4'hC then 4'h3.
  - Data 0xCCDDAABB.
- Same LW with macro off:
  - `exc_misaligned_o` at cycle 1 with `exc_addr_o`=0x1FE.
  - No `mem_req_o`.
- Reset asserted in `WAIT0`, then a late `mem_rvalid_i`:
  - All outputs 0 immediately.
  - Late response ignored.
  - Next LW completes correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the load/store sequencer.
// The LSU_MISALIGN_SPLIT_EN build macro is consumed by lsu_ctrl, not here.
package riscv;

    typedef enum logic [1:0] {
        BYTE     = 2'b00,
        HWORD    = 2'b01,
        WORD     = 2'b10,
        WORD_ALT = 2'b11
    } size_t;

    typedef enum logic {
        SIGNED   = 1'b0,
        UNSIGNED = 1'b1
    } sign_t;

    typedef logic [4:0] reg_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5,
        EXC   = 3'd6
    } lsu_state_t;

    function automatic logic [3:0] lsu_be_mask(input size_t size);
        case (size)
            BYTE:    lsu_be_mask = 4'b0001;
            HWORD:   lsu_be_mask = 4'b0011;
            default: lsu_be_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input size_t size, input logic [1:0] off);
        case (size)
            BYTE:    lsu_misaligned = 1'b0;
            HWORD:   lsu_misaligned = off[0];
            default: lsu_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: store data shifted onto a two-word lane pair,
// load data extracted from a two-word pair and sign/zero extended.
module lsu_align
    import riscv::*;
(
    input  size_t       size_i,
    input  sign_t       sign_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [55:0] rdata_i,
    output logic [63:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  pair_b [8];
    logic [31:0] win;

    assign wdata_o = {32'b0, wdata_i} << {off_i, 3'b000};

    // The top byte of the second word can never fall inside a 4-byte window
    // starting at offset 0..3, so only seven bytes of the pair are carried.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pair
            if (gi < 7) begin : g_live
                assign pair_b[gi] = rdata_i[8*gi +: 8];
            end else begin : g_pad
                assign pair_b[gi] = 8'h00;
            end
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_win
            assign win[8*gi +: 8] = pair_b[3'(gi) + {1'b0, off_i}];
        end
    endgenerate

    always_comb begin
        ldata_o = win;
        case (size_i)
            BYTE:  ldata_o = {{24{(sign_i == SIGNED) & win[7]}}, win[7:0]};
            HWORD: ldata_o = {{16{(sign_i == SIGNED) & win[15]}}, win[15:0]};
            default: ldata_o = win;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one op at a time, up to two memory beats, registered
// writeback and misalignment pulses. Build macro: LSU_MISALIGN_SPLIT_EN.
module lsu_ctrl
    import riscv::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_is_store_i,
    input  size_t           req_size_i,
    input  sign_t           req_sign_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  reg_t            req_rd_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            wb_valid_o,
    output reg_t            wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            exc_misaligned_o,
    output logic [XLEN-1:0] exc_addr_o,
    output logic            busy_o
);

    lsu_state_t      state_q, state_d;
    logic            is_store_q;
    size_t           size_q;
    sign_t           sign_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    reg_t            rd_q;
    logic [XLEN-1:0] rdata0_q;
    logic            wb_valid_q;
    reg_t            wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            exc_q;
    logic [XLEN-1:0] exc_addr_q;

    logic            accept;
    logic            req_unsupported;
    logic            split;
    logic [7:0]      be8;
    logic [XLEN-1:0] beat0_addr;
    logic [XLEN-1:0] beat1_addr;
    logic [63:0]     st_data64;
    logic [XLEN-1:0] ld_lo;
    logic [23:0]     ld_hi;
    logic [XLEN-1:0] ld_data;
    logic            wb_fire;

    assign accept     = req_valid_i && (state_q == IDLE);
    assign be8        = {4'b0000, lsu_be_mask(size_q)} << addr_q[1:0];
    assign beat0_addr = {addr_q[XLEN-1:2], 2'b00};
    assign beat1_addr = beat0_addr + 32'd4;

`ifdef LSU_MISALIGN_SPLIT_EN
    assign req_unsupported = 1'b0;
    assign split           = |be8[7:4];
`else
    assign req_unsupported = lsu_misaligned(req_size_i, req_addr_i[1:0]);
    assign split           = 1'b0;
`endif

    // The final beat's data is still on the bus, so it bypasses the capture register.
    assign ld_lo = (state_q == WAIT1) ? rdata0_q : mem_rdata_i;
    assign ld_hi = (state_q == WAIT1) ? mem_rdata_i[23:0] : 24'h000000;

    lsu_align u_align (
        .size_i  (size_q),
        .sign_i  (sign_q),
        .off_i   (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i ({ld_hi, ld_lo}),
        .wdata_o (st_data64),
        .ldata_o (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_unsupported ? EXC : REQ0;
                end
            end
            REQ0: begin
                mem_req_o   = 1'b1;
                mem_we_o    = is_store_q;
                mem_addr_o  = beat0_addr;
                mem_be_o    = be8[3:0];
                mem_wdata_o = is_store_q ? st_data64[31:0] : '0;
                if (mem_gnt_i) begin
                    state_d = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rvalid_i) begin
                    state_d = split ? REQ1 : DONE;
                end
            end
            REQ1: begin
                mem_req_o   = 1'b1;
                mem_we_o    = is_store_q;
                mem_addr_o  = beat1_addr;
                mem_be_o    = be8[7:4];
                mem_wdata_o = is_store_q ? st_data64[63:32] : '0;
                if (mem_gnt_i) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wb_fire = (state_d == DONE) && !is_store_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            size_q     <= BYTE;
            sign_q     <= SIGNED;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rdata0_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q <= req_is_store_i;
                size_q     <= req_size_i;
                sign_q     <= req_sign_i;
                addr_q     <= req_addr_i;
                wdata_q    <= req_wdata_i;
                rd_q       <= req_rd_i;
            end
            if ((state_q == WAIT0) && mem_rvalid_i) begin
                rdata0_q <= mem_rdata_i;
            end
            wb_valid_q <= wb_fire;
            wb_rd_q    <= wb_fire ? rd_q : '0;
            wb_data_q  <= wb_fire ? ld_data : '0;
            exc_q      <= accept && req_unsupported;
            exc_addr_q <= (accept && req_unsupported) ? req_addr_i : '0;
        end
    end

    assign wb_valid_o       = wb_valid_q;
    assign wb_rd_o          = wb_rd_q;
    assign wb_data_o        = wb_data_q;
    assign exc_misaligned_o = exc_q;
    assign exc_addr_o       = exc_addr_q;
    assign busy_o           = !req_ready_o;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed ops push expected beats/writebacks,
// a monitor pops and compares whenever the DUT presents them.
module tb_lsu_ctrl;
    import riscv::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_is_store_i;
    size_t       req_size_i;
    sign_t       req_sign_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    reg_t        req_rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    reg_t        wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_misaligned_o;
    logic [31:0] exc_addr_o;
    logic        busy_o;

    lsu_ctrl #(.XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_is_store_i   (req_is_store_i),
        .req_size_i       (req_size_i),
        .req_sign_i       (req_sign_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_rd_i         (req_rd_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_be_o         (mem_be_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .wb_rd_o          (wb_rd_o),
        .wb_data_o        (wb_data_o),
        .exc_misaligned_o (exc_misaligned_o),
        .exc_addr_o       (exc_addr_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          held;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } exc_t;

    beat_t       beat_q[$];
    wb_t         wb_q[$];
    exc_t        exc_q[$];
    logic [31:0] rdq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int gnt_delay = 0;
    int rv_delay  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: grant after gnt_delay extra cycles, respond rv_delay cycles later.
    initial begin
        int wcnt;
        int rvcnt;
        wcnt = 0;
        rvcnt = 0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_gnt_i = 1'b0;
            if (rvcnt > 0) begin
                rvcnt--;
                if (rvcnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
                end
            end
            if (mem_req_o) begin
                if (wcnt == gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    rvcnt = rv_delay + 1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        int run;
        beat_t b;
        wb_t w;
        exc_t e;
        run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req_o) begin
                run++;
                if (mem_gnt_i) begin
                    if (beat_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL mem_unexpected: got addr=%h be=%h want no request", mem_addr_o, mem_be_o);
                    end else begin
                        b = beat_q.pop_front();
                        $display("beat cyc=%0d we=%0b addr=%h be=%h wdata=%h", cyc, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
                        chk("mem_we", {31'b0, mem_we_o}, {31'b0, b.we});
                        chk("mem_addr", mem_addr_o, b.addr);
                        chk("mem_be", {28'b0, mem_be_o}, {28'b0, b.be});
                        chk("mem_wdata", mem_wdata_o, b.wdata);
                        chk("mem_held", run, b.held);
                        chk("mem_cycle", cyc, b.cyc);
                    end
                    run = 0;
                end
            end else begin
                run = 0;
            end
            if (wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%h want no writeback", wb_rd_o, wb_data_o);
                end else begin
                    w = wb_q.pop_front();
                    $display("wb cyc=%0d rd=%0d data=%h", cyc, wb_rd_o, wb_data_o);
                    chk("wb_rd", {27'b0, wb_rd_o}, {27'b0, w.rd});
                    chk("wb_data", wb_data_o, w.data);
                    chk("wb_cycle", cyc, w.cyc);
                end
            end
            if (exc_misaligned_o) begin
                if (exc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL exc_unexpected: got addr=%h want no exception", exc_addr_o);
                end else begin
                    e = exc_q.pop_front();
                    $display("exc cyc=%0d addr=%h", cyc, exc_addr_o);
                    chk("exc_addr", exc_addr_o, e.addr);
                    chk("exc_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!req_ready_o && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 60) begin
            total++; bad++;
            $display("FAIL %s_timeout: got ready=0 want ready within 60 cycles", nm);
        end
    endtask

    // nb = number of expected beats; nb = 0 means a misalignment exception.
    task automatic op(input string nm, input logic st, input size_t sz, input sign_t sg,
                      input logic [31:0] a, input logic [31:0] wd, input reg_t rd, input int gd,
                      input logic [31:0] r0, input logic [31:0] r1, input int nb,
                      input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                      input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                      input logic [31:0] exp_data);
        int acc;
        gnt_delay = gd;
        if (nb >= 1) rdq.push_back(r0);
        if (nb == 2) rdq.push_back(r1);
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_is_store_i = st;
        req_size_i     = sz;
        req_sign_i     = sg;
        req_addr_i     = a;
        req_wdata_i    = wd;
        req_rd_i       = rd;
        #1;
        wait_ready(nm);
        acc = cyc;
        $display("op %s cyc=%0d addr=%h beats=%0d", nm, acc, a, nb);
        if (nb >= 1) beat_q.push_back('{st, a0, b0, w0, gd + 1, acc + 1 + gd});
        if (nb == 2) beat_q.push_back('{st, a1, b1, w1, gd + 1, acc + 1 + (gd + 2) + gd});
        if (nb == 0) exc_q.push_back('{a, acc + 1});
        if (nb > 0 && !st) wb_q.push_back('{rd, exp_data, acc + 1 + nb * (gd + 2)});
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = 32'hDEAD_0000;
        #1;
        chk({nm, "_ready_busy"}, {30'b0, req_ready_o, busy_o}, 32'h1);
        wait_ready(nm);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ready"}, {31'b0, req_ready_o}, 32'h1);
        chk({nm, "_busy"}, {31'b0, busy_o}, 32'h0);
        chk({nm, "_mem_req"}, {31'b0, mem_req_o}, 32'h0);
        chk({nm, "_mem_addr_be"}, mem_addr_o | {28'b0, mem_be_o}, 32'h0);
        chk({nm, "_wb"}, {31'b0, wb_valid_o} | wb_data_o, 32'h0);
        chk({nm, "_exc"}, {31'b0, exc_misaligned_o} | exc_addr_o, 32'h0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        req_valid_i = 1'b0;
        req_is_store_i = 1'b0;
        req_size_i = WORD;
        req_sign_i = SIGNED;
        req_addr_i = 32'h0;
        req_wdata_i = 32'h0;
        req_rd_i = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op("lw_aligned", 1'b0, WORD, SIGNED, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 32'h0, 1,
           32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
        op("lb_signed", 1'b0, BYTE, SIGNED, 32'h103, 32'h0, 5'd6, 0, 32'h80123456, 32'h0, 1,
           32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80);
        op("lbu", 1'b0, BYTE, UNSIGNED, 32'h103, 32'h0, 5'd7, 0, 32'h80123456, 32'h0, 1,
           32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080);
        op("sh_gnt_delay", 1'b1, HWORD, SIGNED, 32'h102, 32'h00001234, 5'd0, 3, 32'h0, 32'h0, 1,
           32'h100, 4'hC, 32'h12340000, 32'h0, 4'h0, 32'h0, 32'h0);
        op("lh_signed", 1'b0, HWORD, SIGNED, 32'h102, 32'h0, 5'd8, 1, 32'h80015555, 32'h0, 1,
           32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001);
        op("sb", 1'b1, BYTE, UNSIGNED, 32'h101, 32'h000000A5, 5'd0, 0, 32'h0, 32'h0, 1,
           32'h100, 4'h2, 32'h0000A500, 32'h0, 4'h0, 32'h0, 32'h0);
        op("sw", 1'b1, WORD, SIGNED, 32'h108, 32'hCAFEF00D, 5'd0, 0, 32'h0, 32'h0, 1,
           32'h108, 4'hF, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0, 32'h0);
        op("size11_as_word", 1'b0, WORD_ALT, SIGNED, 32'h10C, 32'h0, 5'd10, 0, 32'h01234567, 32'h0, 1,
           32'h10C, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h01234567);
`ifdef LSU_MISALIGN_SPLIT_EN
        op("lhu_inword", 1'b0, HWORD, UNSIGNED, 32'h101, 32'h0, 5'd11, 0, 32'h00ABCD00, 32'h0, 1,
           32'h100, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000ABCD);
        op("lw_split", 1'b0, WORD, SIGNED, 32'h1FE, 32'h0, 5'd12, 0, 32'hAABB1111, 32'h2222CCDD, 2,
           32'h1FC, 4'hC, 32'h0, 32'h200, 4'h3, 32'h0, 32'hCCDDAABB);
        op("lw_split_wrap", 1'b0, WORD, SIGNED, 32'hFFFFFFFE, 32'h0, 5'd13, 0, 32'h56781111, 32'h22221234, 2,
           32'hFFFFFFFC, 4'hC, 32'h0, 32'h00000000, 4'h3, 32'h0, 32'h12345678);
        op("sh_split", 1'b1, HWORD, SIGNED, 32'h203, 32'h0000BEEF, 5'd0, 1, 32'h0, 32'h0, 2,
           32'h200, 4'h8, 32'hEF000000, 32'h204, 4'h1, 32'h000000BE, 32'h0);
`else
        op("lhu_misaligned", 1'b0, HWORD, UNSIGNED, 32'h101, 32'h0, 5'd11, 0, 32'h0, 32'h0, 0,
           32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
        op("lw_misaligned", 1'b0, WORD, SIGNED, 32'h1FE, 32'h0, 5'd12, 0, 32'h0, 32'h0, 0,
           32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
        op("lw_misaligned_hi", 1'b0, WORD, SIGNED, 32'hFFFFFFFE, 32'h0, 5'd13, 0, 32'h0, 32'h0, 0,
           32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
        op("sh_misaligned", 1'b1, HWORD, SIGNED, 32'h203, 32'h0000BEEF, 5'd0, 0, 32'h0, 32'h0, 0,
           32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
`endif

        // Reset while waiting for a slow response; the late response must be dropped.
        rv_delay  = 5;
        gnt_delay = 0;
        rdq.push_back(32'h11111111);
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_is_store_i = 1'b0;
        req_size_i     = WORD;
        req_sign_i     = SIGNED;
        req_addr_i     = 32'h140;
        req_rd_i       = 5'd3;
        #1;
        wait_ready("rst_lw");
        acc = cyc;
        $display("op rst_lw cyc=%0d addr=%h beats=1", acc, req_addr_i);
        beat_q.push_back('{1'b0, 32'h140, 4'hF, 32'h0, 1, acc + 1});
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("late_rdata_consumed", rdq.size(), 0);
        rv_delay = 0;

        op("lw_after_reset", 1'b0, WORD, SIGNED, 32'h104, 32'h0, 5'd9, 0, 32'h0BADF00D, 32'h0, 1,
           32'h104, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BADF00D);

        repeat (10) @(negedge clk);
        chk("drain_beats", beat_q.size(), 0);
        chk("drain_wb", wb_q.size(), 0);
        chk("drain_exc", exc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
